// File: rtl/report_pkg.sv
`timescale 1ns/1ps
// Shared state type, ASCII constants and sizing helper for answer_uart_reporter.
package report_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, SEND, SENT} reportState_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_N    = 8'h4E;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;

  localparam int ERR_LEN = 3;

  // Decimal digits needed for an unsigned value of the given bit width (log10(2) ~ 0.30103).
  function automatic int MAX_DIGITS(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

  function automatic logic [7:0] errByte(input logic [1:0] idx);
    logic [7:0] value;
    value = ASCII_R;
    if (idx == 2'd0) value = ASCII_E;
    return value;
  endfunction

  function automatic logic [7:0] prefixByte(input logic [1:0] idx);
    logic [7:0] value;
    case (idx)
      2'd0:    value = ASCII_A;
      2'd1:    value = ASCII_N;
      2'd2:    value = ASCII_S;
      default: value = ASCII_EQ;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
`timescale 1ns/1ps
// 8N1 byte serializer with a valid/ready handshake; accepts the next byte in the
// last cycle of the stop bit so consecutive frames run with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_frameEnd,
  output logic       o_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic             r_active;
  logic [CNT_W-1:0] r_baudCnt;
  logic [3:0]       r_bitIdx;
  logic [8:0]       r_shift;
  logic             r_tx;
  logic             w_bitEnd;
  logic             w_accept;

  assign w_bitEnd   = (r_baudCnt == CNT_W'(CLKS_PER_BIT - 1));
  assign o_frameEnd = r_active && w_bitEnd && (r_bitIdx == 4'd9);
  assign o_ready    = !r_active || o_frameEnd;
  assign w_accept   = i_valid && o_ready;
  assign o_tx       = r_tx;

  // r_bitIdx 0 is the start bit, 1..8 data, 9 stop; r_shift holds {stop, remaining data}.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active  <= 1'b0;
      r_baudCnt <= '0;
      r_bitIdx  <= 4'd0;
      r_shift   <= '1;
      r_tx      <= 1'b1;
    end else if (w_accept) begin
      r_active  <= 1'b1;
      r_baudCnt <= '0;
      r_bitIdx  <= 4'd0;
      r_shift   <= {1'b1, i_data};
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_baudCnt <= '0;
        if (r_bitIdx == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bitIdx <= r_bitIdx + 4'd1;
          r_tx     <= r_shift[0];
          r_shift  <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baudCnt <= r_baudCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/answer_uart_reporter.sv
`timescale 1ns/1ps
// Sends the solver's answer (decimal ASCII + CR LF) or "ERR\r\n" once per reset over 8N1 UART.
// Define REPORT_PREFIX_EN to prefix the answer message with "ANS=".
module answer_uart_reporter #(
  parameter int CLK_FREQ_HZ  = 125_000_000,
  parameter int BAUD         = 115_200,
  parameter int ANSWER_WIDTH = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Done,
  input  logic                    Error,
  input  logic [ANSWER_WIDTH-1:0] Answer,
  output logic                    Tx,
  output logic                    Busy,
  output logic                    Sent
);

  import report_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int MAX_DIG      = MAX_DIGITS(ANSWER_WIDTH);
`ifdef REPORT_PREFIX_EN
  localparam int PREFIX_LEN   = 4;
`else
  localparam int PREFIX_LEN   = 0;
`endif
  localparam int MSG_MAX      = PREFIX_LEN + MAX_DIG + 2;
  localparam int IDX_W        = $clog2(MSG_MAX + 1);
  localparam int DCNT_W       = $clog2(MAX_DIG + 1);
  localparam int DSEL_W       = $clog2(MAX_DIG);
  localparam int BIT_W        = $clog2(ANSWER_WIDTH);

  reportState_t            r_state;
  reportState_t            w_stateNext;
  logic                    r_doneQ;
  logic                    r_errorQ;
  logic                    r_isErr;
  logic [ANSWER_WIDTH-1:0] r_dividend;
  logic [3:0]              r_rem;
  logic [BIT_W-1:0]        r_bitCnt;
  logic [3:0]              r_digits [MAX_DIG];
  logic [DCNT_W-1:0]       r_numDigits;
  logic [IDX_W-1:0]        r_msgIdx;
  logic                    r_allIssued;

  logic                    w_doneEdge;
  logic                    w_errEdge;
  logic [4:0]              w_trial;
  logic                    w_geTen;
  logic [3:0]              w_remNext;
  logic [ANSWER_WIDTH-1:0] w_quotNext;
  logic                    w_lastBit;
  logic                    w_convDone;
  logic [IDX_W-1:0]        w_msgLen;
  logic [IDX_W-1:0]        w_digitPos;
  logic [DSEL_W-1:0]       w_digitSel;
  logic [7:0]              w_txByte;
  logic                    w_txValid;
  logic                    w_txReady;
  logic                    w_frameEnd;
  logic                    w_accept;

  assign w_doneEdge = Done && !r_doneQ;
  assign w_errEdge  = Error && !r_errorQ;

  // One restoring-division step: shift the next dividend bit into the remainder, subtract 10 if it fits.
  assign w_trial    = {r_rem, r_dividend[ANSWER_WIDTH-1]};
  assign w_geTen    = (w_trial >= 5'd10);
  assign w_remNext  = w_geTen ? 4'(w_trial - 5'd10) : w_trial[3:0];
  assign w_quotNext = {r_dividend[ANSWER_WIDTH-2:0], w_geTen};
  assign w_lastBit  = (r_bitCnt == BIT_W'(ANSWER_WIDTH - 1));
  assign w_convDone = (r_state == CONVERT) && w_lastBit && (w_quotNext == '0);

  assign w_msgLen   = r_isErr ? IDX_W'(ERR_LEN + 2)
                              : IDX_W'(PREFIX_LEN + 2) + IDX_W'(r_numDigits);
  assign w_digitPos = r_msgIdx - IDX_W'(PREFIX_LEN);
  assign w_digitSel = DSEL_W'(IDX_W'(r_numDigits) - IDX_W'(1) - w_digitPos);
  assign w_accept   = w_txValid && w_txReady;

  assign Busy = (r_state == CONVERT) || (r_state == SEND);
  assign Sent = (r_state == SENT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_txValid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_errEdge)       w_stateNext = SEND;
        else if (w_doneEdge) w_stateNext = CONVERT;
      end
      CONVERT: begin
`ifdef REPORT_PREFIX_EN
        w_txValid = (r_msgIdx < IDX_W'(PREFIX_LEN));
`endif
        if (w_convDone) w_stateNext = SEND;
      end
      SEND: begin
        w_txValid = !r_allIssued;
        if (r_allIssued && w_frameEnd) w_stateNext = SENT;
      end
      SENT:    w_stateNext = SENT;
      default: w_stateNext = IDLE;
    endcase
  end

  // Digits are stored least significant first, so the sender reads the buffer backwards.
  always_comb begin
    w_txByte = ASCII_LF;
    if (r_isErr) begin
      if (r_msgIdx < IDX_W'(ERR_LEN))       w_txByte = errByte(r_msgIdx[1:0]);
      else if (r_msgIdx == IDX_W'(ERR_LEN)) w_txByte = ASCII_CR;
    end else begin
`ifdef REPORT_PREFIX_EN
      if (r_msgIdx < IDX_W'(PREFIX_LEN)) w_txByte = prefixByte(r_msgIdx[1:0]);
      else
`endif
      if (w_digitPos < IDX_W'(r_numDigits))       w_txByte = ASCII_ZERO + {4'd0, r_digits[w_digitSel]};
      else if (w_digitPos == IDX_W'(r_numDigits)) w_txByte = ASCII_CR;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_doneQ     <= 1'b0;
      r_errorQ    <= 1'b0;
      r_isErr     <= 1'b0;
      r_dividend  <= '0;
      r_rem       <= 4'd0;
      r_bitCnt    <= '0;
      r_numDigits <= '0;
      r_msgIdx    <= '0;
      r_allIssued <= 1'b0;
    end else begin
      r_doneQ  <= Done;
      r_errorQ <= Error;
      if (r_state == IDLE) begin
        r_msgIdx    <= '0;
        r_allIssued <= 1'b0;
        r_numDigits <= '0;
        r_rem       <= 4'd0;
        r_bitCnt    <= '0;
        if (w_errEdge) begin
          r_isErr <= 1'b1;
        end else if (w_doneEdge) begin
          r_isErr    <= 1'b0;
          r_dividend <= Answer;
        end
      end else begin
        if (r_state == CONVERT) begin
          r_dividend <= w_quotNext;
          if (w_lastBit) begin
            r_rem       <= 4'd0;
            r_bitCnt    <= '0;
            r_numDigits <= r_numDigits + DCNT_W'(1);
          end else begin
            r_rem    <= w_remNext;
            r_bitCnt <= r_bitCnt + BIT_W'(1);
          end
        end
        if (w_accept) begin
          r_msgIdx <= r_msgIdx + IDX_W'(1);
          if (r_msgIdx == w_msgLen - IDX_W'(1)) r_allIssued <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if ((r_state == CONVERT) && w_lastBit) r_digits[DSEL_W'(r_numDigits)] <= w_remNext;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uartTx (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_valid    (w_txValid),
    .i_data     (w_txByte),
    .o_ready    (w_txReady),
    .o_frameEnd (w_frameEnd),
    .o_tx       (Tx)
  );

endmodule
